fp_addsub_ctrl: RTL and testbench
=================================

// Module: fp_addsub_ctrl
// PURPOSE
//  Sequencer for one single-precision (IEEE-754) add/sub on the shared 24-bit mantissa adder
//  (fullAdder32). Unpacks operands, aligns exponents, loads/enables the adder, normalises its
//  sum and packs the result. One operation in flight; start/done handshake to the requester.
// PARAMETERS
//  EXP_W       8   exponent width
//  MAN_W       23  stored fraction width (adder width = MAN_W+1)
//  ADD_CYCLES  2   enable cycles after load before the adder sum is taken (adder sign fix-up)
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   asynchronous active-low reset
//  start        in   1   request; sampled only in IDLE
//  op_sub       in   1   0 = A+B, 1 = A-B
//  op_a, op_b   in   32  IEEE-754 operands, sampled with start
//  busy         out  1   high from accepted start until done
//  done         out  1   one-cycle pulse, result valid
//  result       out  32  packed result, held until next accepted start
//  ovf, unf     out  1   overflow / underflow flags, valid with done, held
//  add_rst      out  1   adder sync reset (active high)
//  add_en       out  1   adder enable
//  add_load     out  1   adder load
//  add_pm       out  1   adder PlusOrMinus
//  add_a, add_b out  24  aligned mantissas (hidden bit included)
//  add_sa,add_sb out 1   operand signs to adder
//  add_cin      out  1   carry-in, tied 0
//  add_sum      in   24  adder sum;  add_cout in 1 carry;  add_sgn in 1 result sign
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE; busy, done, result, ovf, unf, add_en, add_load, add_pm,
//   add_a, add_b, add_sa, add_sb = 0; add_rst = 1. Reset mid-operation aborts, no done.
//  States: IDLE -> UNPACK -> ALIGN -> LOAD -> ADD -> NORM -> PACK -> IDLE.
//  IDLE: add_rst=1. start=1 latches operands/op_sub, busy=1 next cycle. start while busy ignored.
//  UNPACK (1 cyc): add_rst=0; hidden bit = (exp!=0); exp==0 operand treated as zero mantissa.
//   Larger-exponent operand kept; diff=|ea-eb|; res_exp=max(ea,eb).
//  ALIGN: smaller mantissa >>1 per cycle, diff decrements; exits at diff==0. diff>=24: mantissa
//   set to 0 in one cycle. Truncate, no guard/sticky. Latency 1..23 cycles (1 if diff 0).
//  LOAD (1 cyc): add_en=1, add_load=1, add_pm=op_sub, add_a/add_b/add_sa/add_sb driven;
//   all held stable through ADD (adder reads live signs).
//  ADD: add_en=1, add_load=0 for ADD_CYCLES cycles; then capture add_sum/add_cout/add_sgn.
//  NORM: cout=1 -> mantissa >>1 with cout into MSB, exp+1 (1 cyc). Sum==0 -> result +0, go PACK.
//   Else while mant[23]==0: <<1, exp-1, one bit per cycle (<=23 cyc). Exp reaching 0 before
//   normalised -> result +0, unf=1. Exp reaching 2^EXP_W-1 -> +/-Inf, ovf=1.
//  PACK (1 cyc): result={sgn,exp,mant[22:0]}; done=1 this cycle; busy=0 next cycle; add_rst=1.
//  Worst-case latency start->done: 1+1+23+1+ADD_CYCLES+23+1 cycles.
//  Width rules: exponent arithmetic in EXP_W+1 bits; diff saturates at 24.
// CONFIGURATION
//  FP_CTRL_SPECIAL_EN defined: UNPACK detects exp==all-ones. NaN in -> 0x7FC00000; Inf+Inf
//   same sign -> that Inf; Inf-Inf -> 0x7FC00000; Inf+finite -> Inf; skips ALIGN..NORM,
//   done 2 cycles after start accepted. ovf/unf=0 on these paths.
//  Undefined: all-ones exponents processed as ordinary numbers, no bypass.
// TESTING
//  1) A=0x3F800000 B=0x3F800000 op_sub=0 -> result 0x40000000, ovf=unf=0, one done pulse.
//  2) A=0x3FC00000 B=0x3F000000 op_sub=1 -> 0x3F800000 (1.5-0.5).
//  3) A=0x3F800000 B=0x30800000 (diff>=24) -> 0x3F800000, ALIGN takes 1 cycle.
//  4) A=0x40400000 B=0x40400000 op_sub=1 -> 0x00000000, unf=0.
//  5) start pulsed again while busy -> ignored, single done; rst=0 during ALIGN -> busy=0,
//     done never asserted, add_rst=1, next op completes correctly.
//  6) Macro on: A=0x7F800000 B=0x3F800000 -> 0x7F800000 in 2 cycles; A=B=0x7F800000 op_sub=1
//     -> 0x7FC00000.

Source files
------------

// File: rtl/fp_addsub_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fp_addsub_ctrl_if                                               |
// | Brief    : Requester-side start/done handshake for fp_addsub_ctrl.         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface fp_addsub_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op_sub;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             ovf;
    logic             unf;

    modport master (
        output start, op_sub, op_a, op_b,
        input  busy, done, result, ovf, unf
    );

    modport slave (
        input  start, op_sub, op_a, op_b,
        output busy, done, result, ovf, unf
    );
endinterface
`default_nettype wire

// File: rtl/fp_addsub_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fp_addsub_ctrl                                                  |
// | Brief    : Sequences one IEEE-754 add/sub on an external mantissa adder.   |
// |            Define FP_CTRL_SPECIAL_EN to bypass NaN/Inf operands.           |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module fp_addsub_ctrl #(
    parameter int EXP_W      = 8,
    parameter int MAN_W      = 23,
    parameter int ADD_CYCLES = 2
) (
    input  wire logic           clk,
    input  wire logic           rst,
    fp_addsub_ctrl_if.slave     req,
    output logic                add_rst,
    output logic                add_en,
    output logic                add_load,
    output logic                add_pm,
    output logic [MAN_W:0]      add_a,
    output logic [MAN_W:0]      add_b,
    output logic                add_sa,
    output logic                add_sb,
    output logic                add_cin,
    input  wire logic [MAN_W:0] add_sum,
    input  wire logic           add_cout,
    input  wire logic           add_sgn
);
    localparam int MW     = MAN_W + 1;
    localparam int DW     = 1 + EXP_W + MAN_W;
    localparam int DIFF_W = $clog2(MW + 1);
    localparam int CNT_W  = $clog2(ADD_CYCLES + 1);

    localparam logic [EXP_W:0]    EXP_MAX  = {1'b0, {EXP_W{1'b1}}};
    localparam logic [EXP_W:0]    EXP_ONE  = (EXP_W+1)'(1);
    localparam logic [EXP_W:0]    MW_E     = (EXP_W+1)'(MW);
    localparam logic [DIFF_W-1:0] DIFF_SAT = DIFF_W'(MW);
    localparam logic [DIFF_W-1:0] DIFF_ONE = DIFF_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ADD_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        UNPACK = 3'd1,
        ALIGN  = 3'd2,
        LOAD   = 3'd3,
        ADD    = 3'd4,
        NORM   = 3'd5,
        PACK   = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [DW-1:0]     opa_q, opa_d, opb_q, opb_d, result_q, result_d;
    logic              sub_q, sub_d, busy_q, busy_d, ovf_q, ovf_d, unf_q, unf_d;
    logic [MW-1:0]     man_a_q, man_a_d, man_b_q, man_b_d, norm_q, norm_d;
    logic              sa_q, sa_d, sb_q, sb_d, shift_b_q, shift_b_d;
    logic              cout_q, cout_d, sgn_q, sgn_d;
    logic [EXP_W:0]    exp_q, exp_d;
    logic [DIFF_W-1:0] diff_q, diff_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [EXP_W:0]    w_ea, w_eb, w_ediff, w_exp_inc, w_exp_dec;

`ifdef FP_CTRL_SPECIAL_EN
    localparam logic [DW-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    logic w_a_nan, w_a_inf, w_b_nan, w_b_inf, w_sb_eff;
`endif

    always_comb begin
        state_d   = state_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        sub_d     = sub_q;
        busy_d    = busy_q;
        result_d  = result_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        man_a_d   = man_a_q;
        man_b_d   = man_b_q;
        norm_d    = norm_q;
        sa_d      = sa_q;
        sb_d      = sb_q;
        shift_b_d = shift_b_q;
        cout_d    = cout_q;
        sgn_d     = sgn_q;
        exp_d     = exp_q;
        diff_d    = diff_q;
        cnt_d     = cnt_q;

        w_ea      = {1'b0, opa_q[DW-2 -: EXP_W]};
        w_eb      = {1'b0, opb_q[DW-2 -: EXP_W]};
        w_ediff   = (w_ea >= w_eb) ? (w_ea - w_eb) : (w_eb - w_ea);
        w_exp_inc = exp_q + EXP_ONE;
        w_exp_dec = exp_q - EXP_ONE;
`ifdef FP_CTRL_SPECIAL_EN
        w_a_nan   = (w_ea == EXP_MAX) && (|opa_q[MAN_W-1:0]);
        w_a_inf   = (w_ea == EXP_MAX) && !(|opa_q[MAN_W-1:0]);
        w_b_nan   = (w_eb == EXP_MAX) && (|opb_q[MAN_W-1:0]);
        w_b_inf   = (w_eb == EXP_MAX) && !(|opb_q[MAN_W-1:0]);
        w_sb_eff  = opb_q[DW-1] ^ sub_q;
`endif

        case (state_q)
            IDLE: begin
                if (req.start) begin
                    opa_d   = req.op_a;
                    opb_d   = req.op_b;
                    sub_d   = req.op_sub;
                    busy_d  = 1'b1;
                    state_d = UNPACK;
                end
            end
            UNPACK: begin
                // Zero exponent means zero mantissa: no denormal support.
                man_a_d   = (w_ea != '0) ? {1'b1, opa_q[MAN_W-1:0]} : '0;
                man_b_d   = (w_eb != '0) ? {1'b1, opb_q[MAN_W-1:0]} : '0;
                sa_d      = opa_q[DW-1];
                sb_d      = opb_q[DW-1];
                shift_b_d = (w_ea >= w_eb);
                exp_d     = (w_ea >= w_eb) ? w_ea : w_eb;
                diff_d    = (w_ediff >= MW_E) ? DIFF_SAT : w_ediff[DIFF_W-1:0];
                state_d   = ALIGN;
`ifdef FP_CTRL_SPECIAL_EN
                if (w_a_nan || w_b_nan || w_a_inf || w_b_inf) begin
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    state_d = PACK;
                    if (w_a_nan || w_b_nan)
                        result_d = QNAN;
                    else if (w_a_inf && w_b_inf)
                        result_d = (opa_q[DW-1] == w_sb_eff) ? {opa_q[DW-1], opa_q[DW-2:0]} : QNAN;
                    else if (w_a_inf)
                        result_d = opa_q;
                    else
                        result_d = {w_sb_eff, opb_q[DW-2:0]};
                end
`endif
            end
            ALIGN: begin
                // Operands stay in their slots so A-B keeps its sign semantics.
                if (diff_q == DIFF_SAT) begin
                    if (shift_b_q) man_b_d = '0;
                    else           man_a_d = '0;
                    diff_d  = '0;
                    state_d = LOAD;
                end else if (diff_q == '0) begin
                    state_d = LOAD;
                end else begin
                    if (shift_b_q) man_b_d = man_b_q >> 1;
                    else           man_a_d = man_a_q >> 1;
                    diff_d = diff_q - DIFF_ONE;
                    if (diff_q == DIFF_ONE) state_d = LOAD;
                end
            end
            LOAD: begin
                cnt_d   = '0;
                state_d = ADD;
            end
            ADD: begin
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    norm_d  = add_sum;
                    cout_d  = add_cout;
                    sgn_d   = add_sgn;
                    state_d = NORM;
                end
            end
            NORM: begin
                if (cout_q) begin
                    norm_d = {1'b1, norm_q[MW-1:1]};
                    cout_d = 1'b0;
                    exp_d  = w_exp_inc;
                    if (w_exp_inc >= EXP_MAX) begin
                        result_d = {sgn_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        ovf_d    = 1'b1;
                        unf_d    = 1'b0;
                        state_d  = PACK;
                    end
                end else if (norm_q == '0) begin
                    result_d = '0;
                    ovf_d    = 1'b0;
                    unf_d    = 1'b0;
                    state_d  = PACK;
                end else if (norm_q[MW-1]) begin
                    ovf_d   = (exp_q >= EXP_MAX);
                    unf_d   = 1'b0;
                    state_d = PACK;
                    if (exp_q >= EXP_MAX)
                        result_d = {sgn_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    else
                        result_d = {sgn_q, exp_q[EXP_W-1:0], norm_q[MAN_W-1:0]};
                end else begin
                    norm_d = norm_q << 1;
                    exp_d  = w_exp_dec;
                    if (w_exp_dec == '0) begin
                        result_d = '0;
                        ovf_d    = 1'b0;
                        unf_d    = 1'b1;
                        state_d  = PACK;
                    end
                end
            end
            PACK: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            opa_q     <= '0;
            opb_q     <= '0;
            sub_q     <= 1'b0;
            busy_q    <= 1'b0;
            result_q  <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            man_a_q   <= '0;
            man_b_q   <= '0;
            norm_q    <= '0;
            sa_q      <= 1'b0;
            sb_q      <= 1'b0;
            shift_b_q <= 1'b0;
            cout_q    <= 1'b0;
            sgn_q     <= 1'b0;
            exp_q     <= '0;
            diff_q    <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            sub_q     <= sub_d;
            busy_q    <= busy_d;
            result_q  <= result_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            man_a_q   <= man_a_d;
            man_b_q   <= man_b_d;
            norm_q    <= norm_d;
            sa_q      <= sa_d;
            sb_q      <= sb_d;
            shift_b_q <= shift_b_d;
            cout_q    <= cout_d;
            sgn_q     <= sgn_d;
            exp_q     <= exp_d;
            diff_q    <= diff_d;
            cnt_q     <= cnt_d;
        end
    end

    assign req.busy   = busy_q;
    assign req.done   = (state_q == PACK);
    assign req.result = result_q;
    assign req.ovf    = ovf_q;
    assign req.unf    = unf_q;

    assign add_rst  = (state_q == IDLE) || (state_q == PACK);
    assign add_en   = (state_q == LOAD) || (state_q == ADD);
    assign add_load = (state_q == LOAD);
    assign add_pm   = sub_q;
    assign add_a    = man_a_q;
    assign add_b    = man_b_q;
    assign add_sa   = sa_q;
    assign add_sb   = sb_q;
    assign add_cin  = 1'b0;
endmodule
`default_nettype wire

// File: tb/tb_fp_addsub_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_fp_addsub_ctrl                                               |
// | Brief    : Directed self-checking bench for fp_addsub_ctrl with a          |
// |            sign-magnitude model of the external mantissa adder.            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_fp_addsub_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp_addsub_ctrl_if #(.WIDTH(32)) req();

    logic        add_rst, add_en, add_load, add_pm, add_sa, add_sb, add_cin;
    logic [23:0] add_a, add_b, add_sum;
    logic        add_cout, add_sgn;
    logic [24:0] adder_tmp;
    logic        adder_sb_eff;

    fp_addsub_ctrl #(.EXP_W(8), .MAN_W(23), .ADD_CYCLES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req.slave),
        .add_rst  (add_rst),
        .add_en   (add_en),
        .add_load (add_load),
        .add_pm   (add_pm),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_sa   (add_sa),
        .add_sb   (add_sb),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout),
        .add_sgn  (add_sgn)
    );

    // Sign-magnitude adder: result = (sa)A +/- (sb)B, magnitude plus sign out.
    always_comb begin
        adder_sb_eff = add_sb ^ add_pm;
        adder_tmp    = '0;
        add_sum      = '0;
        add_cout     = 1'b0;
        add_sgn      = 1'b0;
        if (!add_rst) begin
            if (add_sa == adder_sb_eff) begin
                adder_tmp = {1'b0, add_a} + {1'b0, add_b};
                add_sum   = adder_tmp[23:0];
                add_cout  = adder_tmp[24];
                add_sgn   = add_sa;
            end else if (add_a >= add_b) begin
                add_sum = add_a - add_b;
                add_sgn = add_sa;
            end else begin
                add_sum = add_b - add_a;
                add_sgn = adder_sb_eff;
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int load_cnt = 0;
    int en_cnt   = 0;

    always @(negedge clk) begin
        if (req.done === 1'b1) done_cnt++;
        if (add_load === 1'b1) load_cnt++;
        if (add_en === 1'b1)   en_cnt++;
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sub, output int lat);
        @(negedge clk);
        req.op_a   = a;
        req.op_b   = b;
        req.op_sub = sub;
        req.start  = 1'b1;
        @(posedge clk);
        #1;
        req.start = 1'b0;
        lat = 1;
        while (req.done !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (req.done !== 1'b1) check_value("timeout", 32'(req.done), 32'd1);
    endtask

    task automatic op_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic sub, input logic [31:0] exp_res, input logic [1:0] exp_flags,
                            output int lat);
        run_op(a, b, sub, lat);
        check_value({tag, "_result"}, req.result, exp_res);
        check_value({tag, "_flags"}, 32'({req.ovf, req.unf}), 32'(exp_flags));
        @(posedge clk);
        #1;
        check_value({tag, "_done_pulse"}, 32'({req.done, req.busy}), 32'd0);
    endtask

    int lat;
    int d0, l0, e0;

    initial begin
        req.start  = 1'b0;
        req.op_sub = 1'b0;
        req.op_a   = '0;
        req.op_b   = '0;
        rst        = 1'b0;
        repeat (3) @(negedge clk);
        check_value("rst_busy_done", 32'({req.busy, req.done}), 32'd0);
        check_value("rst_result", req.result, 32'h0);
        check_value("rst_flags", 32'({req.ovf, req.unf}), 32'd0);
        check_value("rst_add_ctl", 32'({add_rst, add_en, add_load, add_pm}), 32'b1000);
        check_value("rst_add_ab", 32'({add_a, add_sa, add_sb}) ^ 32'(add_b), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // 1.0 + 1.0: carry-out normalisation, one extra NORM cycle.
        d0 = done_cnt; l0 = load_cnt; e0 = en_cnt;
        op_check("t1", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 2'b00, lat);
        check_value("t1_latency", 32'(lat), 32'd8);
        check_value("t1_done_count", 32'(done_cnt - d0), 32'd1);
        check_value("t1_load_cycles", 32'(load_cnt - l0), 32'd1);
        check_value("t1_en_cycles", 32'(en_cnt - e0), 32'd3);

        op_check("t2", 32'h3FC00000, 32'h3F000000, 1'b1, 32'h3F800000, 2'b00, lat);
        op_check("t3", 32'h3F800000, 32'h30800000, 1'b0, 32'h3F800000, 2'b00, lat);
        check_value("t3_latency", 32'(lat), 32'd7);
        op_check("t4", 32'h40400000, 32'h40400000, 1'b1, 32'h00000000, 2'b00, lat);
        op_check("neg_sub", 32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 2'b00, lat);
        op_check("neg_add", 32'hBF800000, 32'hBF800000, 1'b0, 32'hC0000000, 2'b00, lat);
        op_check("ovf", 32'h7F000000, 32'h7F000000, 1'b0, 32'h7F800000, 2'b10, lat);
        op_check("unf", 32'h00800000, 32'h00C00000, 1'b1, 32'h00000000, 2'b01, lat);

        // start held high with new operands while busy must be ignored.
        d0 = done_cnt;
        @(negedge clk);
        req.op_a = 32'h3FC00000; req.op_b = 32'h3F000000; req.op_sub = 1'b1; req.start = 1'b1;
        @(posedge clk);
        #1;
        req.op_a = 32'h40400000; req.op_b = 32'h3F800000; req.op_sub = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        req.start = 1'b0;
        lat = 0;
        while (req.done !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_value("busy_start_result", req.result, 32'h3F800000);
        repeat (30) @(posedge clk);
        check_value("busy_start_done_count", 32'(done_cnt - d0), 32'd1);

        // Asynchronous reset while aligning (8.0 + 1.0 needs three shifts).
        @(negedge clk);
        req.op_a = 32'h41000000; req.op_b = 32'h3F800000; req.op_sub = 1'b0; req.start = 1'b1;
        @(posedge clk);
        #1;
        req.start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_value("abort_busy_done", 32'({req.busy, req.done}), 32'd0);
        check_value("abort_add_rst", 32'({add_rst, add_en}), 32'b10);
        check_value("abort_result", req.result, 32'h0);
        d0 = done_cnt;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check_value("abort_no_done", 32'(done_cnt - d0), 32'd0);
        op_check("after_abort", 32'h41000000, 32'h3F800000, 1'b0, 32'h41100000, 2'b00, lat);

`ifdef FP_CTRL_SPECIAL_EN
        op_check("inf_fin", 32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 2'b00, lat);
        check_value("inf_fin_latency", 32'(lat), 32'd2);
        op_check("inf_sub_inf", 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 2'b00, lat);
        op_check("inf_add_inf", 32'hFF800000, 32'hFF800000, 1'b0, 32'hFF800000, 2'b00, lat);
        op_check("nan_in", 32'h3F800000, 32'h7F800001, 1'b0, 32'h7FC00000, 2'b00, lat);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
